// File: rtl/scmi_doorbell_dispatcher_pkg.sv
// scmi_dispatch_pkg: shared types and helpers for the SCMI doorbell dispatcher.
// Rev 1.0
`default_nettype none

package scmi_dispatch_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic int ch_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin successor of a channel id, wrapping modulo n.
  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scmi_doorbell_dispatcher_if.sv
// scmi_doorbell_dispatcher_if: doorbell, claim and completion signals of the dispatcher.
// Rev 1.0
`default_nettype none

interface scmi_doorbell_dispatcher_if
  import scmi_dispatch_pkg::*;
#(
  parameter int NUM_CHANNELS = 1
);

  localparam int CH_ID_WIDTH = ch_id_width(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] doorbell_i;
  logic [NUM_CHANNELS-1:0] enable_i;
  logic                    irq_o;
  logic                    claim_valid_o;
  logic [CH_ID_WIDTH-1:0]  claim_id_o;
  logic                    claim_ready_i;
  logic                    complete_valid_i;
  logic [CH_ID_WIDTH-1:0]  complete_id_i;
  logic [NUM_CHANNELS-1:0] pending_o;
  logic [NUM_CHANNELS-1:0] active_o;
  logic                    spurious_o;

  modport master (
    output doorbell_i, enable_i, claim_ready_i, complete_valid_i, complete_id_i,
    input  irq_o, claim_valid_o, claim_id_o, pending_o, active_o, spurious_o
  );

  modport slave (
    input  doorbell_i, enable_i, claim_ready_i, complete_valid_i, complete_id_i,
    output irq_o, claim_valid_o, claim_id_o, pending_o, active_o, spurious_o
  );

endinterface

`default_nettype wire

// File: rtl/scmi_doorbell_dispatcher_rr_arb.sv
// scmi_doorbell_rr_arb: picks the first eligible channel at or after the pointer, wrapping.
// Rev 1.0
`default_nettype none

module scmi_doorbell_rr_arb
  import scmi_dispatch_pkg::*;
#(
  parameter  int NUM_CHANNELS = 1,
  localparam int CH_ID_WIDTH  = ch_id_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] eligible,
  input  logic [CH_ID_WIDTH-1:0]  ptr,
  output logic [CH_ID_WIDTH-1:0]  pick_id,
  output logic                    pick_valid
);

  logic [CH_ID_WIDTH-1:0] idx;

  // Scan from the farthest offset down so the nearest eligible channel wins.
  always_comb begin
    pick_id    = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      idx = CH_ID_WIDTH'((int'(ptr) + k) % NUM_CHANNELS);
      if (eligible[idx]) begin
        pick_id    = idx;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/scmi_doorbell_dispatcher.sv
// scmi_doorbell_dispatcher: turns level doorbells into pending events and offers them to the core.
// Rev 1.0
`default_nettype none

module scmi_doorbell_dispatcher
  import scmi_dispatch_pkg::*;
#(
  parameter int NUM_CHANNELS = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  scmi_doorbell_dispatcher_if.slave  bus
);

  localparam int CH_ID_WIDTH = ch_id_width(NUM_CHANNELS);

  state_e                  state;
  state_e                  state_next;
  logic [CH_ID_WIDTH-1:0]  claim_id;
  logic [CH_ID_WIDTH-1:0]  claim_id_next;
  logic [CH_ID_WIDTH-1:0]  rr_ptr;
  logic [NUM_CHANNELS-1:0] prev;
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] active;
  logic                    armed;
  logic                    irq;
  logic                    spurious;

  logic [NUM_CHANNELS-1:0] event_vec;
  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] clr_claim;
  logic [NUM_CHANNELS-1:0] clr_cmp;
  logic [CH_ID_WIDTH-1:0]  pick_id;
  logic                    pick_valid;
  logic                    handshake;
  logic                    cmp_hit;

  scmi_doorbell_rr_arb #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_arb (
    .eligible   (eligible),
    .ptr        (rr_ptr),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  // Doorbells already high when reset releases are absorbed into history, not counted as events.
  always_comb begin
    event_vec = {NUM_CHANNELS{armed}} & bus.doorbell_i & ~prev;
    eligible  = pending & bus.enable_i & ~active;
    cmp_hit   = bus.complete_valid_i
                && (int'(bus.complete_id_i) < NUM_CHANNELS)
                && active[bus.complete_id_i];
    clr_claim = '0;
    clr_cmp   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      clr_claim[c] = handshake && (claim_id == CH_ID_WIDTH'(c));
      clr_cmp[c]   = cmp_hit && (bus.complete_id_i == CH_ID_WIDTH'(c));
    end
  end

  always_comb begin
    state_next    = state;
    claim_id_next = claim_id;
    handshake     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next    = OFFER;
          claim_id_next = pick_id;
        end
      end
      OFFER: begin
        if (bus.claim_ready_i) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      claim_id <= '0;
    end else begin
      state    <= state_next;
      claim_id <= claim_id_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed    <= 1'b0;
      prev     <= '0;
      pending  <= '0;
      active   <= '0;
      rr_ptr   <= '0;
      irq      <= 1'b0;
      spurious <= 1'b0;
    end else begin
      armed    <= 1'b1;
      prev     <= bus.doorbell_i;
      pending  <= (pending & ~clr_claim) | event_vec;
      active   <= (active & ~clr_cmp) | clr_claim;
      irq      <= |eligible;
      spurious <= bus.complete_valid_i & ~cmp_hit;
      if (handshake) begin
        rr_ptr <= CH_ID_WIDTH'(rr_next(int'(claim_id), NUM_CHANNELS));
      end
    end
  end

  assign bus.irq_o         = irq;
  assign bus.claim_valid_o = (state == OFFER);
  assign bus.claim_id_o    = claim_id;
  assign bus.pending_o     = pending;
  assign bus.active_o      = active;
  assign bus.spurious_o    = spurious;

endmodule

`default_nettype wire

// File: doc/scmi_doorbell_dispatcher.md
Name: scmi_doorbell_dispatcher

Overview:
- Sits directly downstream of the SCMI mailbox's per-channel doorbell interrupt lines (agent-to-platform).
- Converts level doorbells into per-channel pending events and raises one interrupt to the PULP controller core.
- Core claims one channel at a time (round-robin), services it, then signals completion.
- Guarantees no doorbell is lost while a channel is in service, and never offers a channel twice concurrently.

Parameters:
- NumChannels, 1, number of SCMI channels / doorbell lines.
- ChIdWidth, max(1,$clog2(NumChannels)), localparam; width of channel ids.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- doorbell_i  in  NumChannels  level doorbells from mailbox (may be asynchronous-free; same clock domain).
- enable_i  in  NumChannels  per-channel enable; masks irq and claim eligibility, not pending capture.
- irq_o  out  1  level interrupt to core: any enabled, pending, non-active channel.
- claim_valid_o  out  1  channel offered for service.
- claim_id_o  out  ChIdWidth  offered channel id.
- claim_ready_i  in  1  core accepts offer.
- complete_valid_i  in  1  one-cycle completion strobe.
- complete_id_i  in  ChIdWidth  channel being completed.
- pending_o  out  NumChannels  pending status.
- active_o  out  NumChannels  in-service status.
- spurious_o  out  1  one-cycle pulse: completion for non-active or out-of-range id.

Behaviour:
- Reset (rst_i high at clock edge):
  - pending, active, doorbell history, rr pointer all 0.
  - FSM IDLE; all outputs 0.
  - rst_i mid-offer drops claim_valid_o next cycle with no handshake.
- Edge detect: event[c] = doorbell_i[c] & ~prev[c]; prev registered every cycle. A doorbell held high yields exactly one event.
- pending_next[c] = (pending[c] & ~clr_claim[c]) | event[c]. An event in the same cycle as the claim of c leaves pending=1 (re-arm).
- Eligible[c] = pending & enable & ~active.
- irq_o registered: irq_o(t+1) = |eligible(t).
- FSM, two states:
  - IDLE:
    - If |eligible, load claim_id from the round-robin pick (first eligible at or after rr pointer, wrapping modulo NumChannels).
    - Assert claim_valid_o next cycle; go to OFFER.
  - OFFER:
    - claim_valid_o=1; claim_id_o is held stable until the handshake. The offer is not retracted if enable or doorbell changes.
    - On valid&ready: pending[id] cleared, active[id] set, rr pointer = id+1 (wraps), return to IDLE.
    - claim_valid_o is 0 for at least one cycle between offers.
- Latency, with doorbell_i rising at cycle t:
  - pending_o high at t+1.
  - irq_o and claim_valid_o high at t+2.
  - After a handshake at cycle h: active_o visible at h+1; the next offer can appear at h+2.
- Completion: complete_valid_i with active[id]=1 clears active[id] next cycle. Otherwise nothing changes and spurious_o pulses next cycle.
- Simultaneous completion and handshake (necessarily different ids): both take effect.
- NumChannels=1: id is always 0; rr pointer is a constant.
- No counters overflow; all state is bounded.

Decomposition:
- Shared package scmi_dispatch_pkg holds:
  - enum state_e {IDLE, OFFER};
  - function rr_next(id) implementing modulo-NumChannels wrap.
- Sub-module scmi_doorbell_rr_arb (combinational): eligible vector + pointer in, picked id + any-valid out.
- The top level holds all registers.

Test Plan (NumChannels=4, enable_i=4'hF unless stated):
- Doorbell[2] rises at cycle 10 and stays high 20 cycles -> pending_o=4'b0100 at 11; irq_o and claim_valid_o with id=2 at 12; exactly one event.
- Doorbells 0,1,3 rise together, core acks every offer, completes immediately -> claim order 0,1,3; rr pointer then 0; irq_o low after the last handshake.
- Offer id=1 with claim_ready_i low 15 cycles while enable_i[1] drops -> claim_id_o stays 1, valid stays high until ready.
- Channel 0 active; doorbell[0] toggles to produce a new event -> pending[0]=1, no offer until complete_id=0; then offered again.
- complete_id=3 when active=4'b0000 -> spurious_o pulse 1 cycle; pending/active unchanged.
- rst_i asserted during OFFER with pending=4'b1010 -> next cycle all outputs 0; doorbells still high after release produce no events (prev tracked from first post-reset cycle). The bench expects events only on fresh rises.
